fb_write_sequencer: RTL and testbench
=====================================

// Module: fb_write_sequencer
// PURPOSE
//  Sequences an incoming byte stream into port A (8-bit write side) of the multimem
//  dual-port framebuffer. Memory is split into two banks on address MSB: front bank is
//  scanned out via port B by the display logic; back bank is filled here. A completed
//  back frame is promoted to front only on the display's frame-boundary pulse (tear-free).
// PARAMETERS
//  ADDR_W       12    port A address width; bit ADDR_W-1 is bank select
//  DATA_W       8     port A data width
//  FRAME_BYTES  2048  bytes per frame; 1 <= FRAME_BYTES <= 2**(ADDR_W-1)
// PORTS
//  clk              in   1        system clock
//  reset            in   1        asynchronous, active-high
//  frame_start      in   1        pulse: begin new frame, write pointer -> 0
//  in_valid         in   1        byte-stream valid
//  in_data          in   DATA_W   byte-stream data
//  in_ready         out  1        byte-stream ready (= state==WRITE)
//  swap_req         in   1        pulse from display at frame boundary (vsync)
//  ram_a_address    out  ADDR_W   to multimem AddressA = {back_bank, ptr}
//  ram_a_data_in    out  DATA_W   to multimem DataInA
//  ram_a_clk_enable out  1        to multimem ClockEnA
//  ram_a_wr         out  1        to multimem WrA
//  front_bank       out  1        bank currently displayed; read side uses as AddressB MSB
//  frame_done       out  1        1-cycle pulse when swap executes
//  short_frame_err  out  1        sticky: frame_start arrived mid-frame
//  dropped_frame_err out 1        sticky: pending frame overwritten before swap
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, front_bank=0 (back bank=1); all outputs 0 incl. errors.
//  - States: IDLE, WRITE, PENDING. frame_start has priority over all other events.
//  - IDLE: in_ready=0. frame_start -> WRITE, ptr=0. swap_req ignored.
//  - WRITE: each in_valid&in_ready handshake registers a write: next cycle
//    ram_a_wr=ram_a_clk_enable=1, ram_a_address={~front_bank,ptr}, ram_a_data_in=in_data;
//    strobes are high exactly one cycle per byte (1-cycle latency). ptr increments.
//    Handshake at ptr==FRAME_BYTES-1 -> PENDING (that final write still issues); ptr=0.
//  - PENDING: in_ready=0. swap_req -> front_bank toggles, frame_done pulses same cycle
//    as the toggle is registered, -> IDLE. swap_req in the cycle the final byte is
//    accepted (still WRITE) is missed; swap waits for the next swap_req.
//  - frame_start in WRITE with ptr!=0: short_frame_err<=1, ptr=0, stay WRITE.
//    A simultaneous in_valid handshake completes but the byte is discarded (no write).
//  - frame_start in PENDING: dropped_frame_err<=1, -> WRITE, ptr=0, front_bank unchanged.
//  - frame_start and swap_req together in PENDING: frame_start wins; no swap.
//  - ptr never exceeds FRAME_BYTES-1; address never touches front bank.
//  - Error flags clear only on reset. No write ever issued outside WRITE handshakes.
// TESTING (bench overrides FRAME_BYTES=4)
//  1 reset mid-WRITE -> all outputs 0, front_bank=0, in_ready=0 next cycle.
//  2 frame_start, bytes "A","B","C","D" back-to-back -> wr pulses at addr
//    12'h800..12'h803 with data A..D, state PENDING, in_ready=0.
//  3 then swap_req -> front_bank=1, frame_done 1 cycle; next frame writes 12'h000..003.
//  4 swap_req coincident with 4th byte accept -> no swap; later swap_req swaps.
//  5 frame_start after 2 bytes -> short_frame_err=1, next byte "Z" written at ptr 0.
//  6 frame_start while PENDING (with swap_req same cycle) -> dropped_frame_err=1,
//    front_bank unchanged, refill of same back bank from ptr 0.

Source files
------------

// File: rtl/fb_write_sequencer.sv
// Byte-stream sequencer that fills the back bank of a double-buffered framebuffer over port A.
// A completed back frame is promoted to the front bank only on the display's swap request.
module fb_write_sequencer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_BYTES = 2048
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_swap_req,
  output logic [ADDR_W-1:0] o_ram_a_address,
  output logic [DATA_W-1:0] o_ram_a_data_in,
  output logic              o_ram_a_clk_enable,
  output logic              o_ram_a_wr,
  output logic              o_front_bank,
  output logic              o_frame_done,
  output logic              o_short_frame_err,
  output logic              o_dropped_frame_err
);

  localparam int unsigned     PtrW    = ADDR_W - 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StPending} state_e;

  state_e              r_state;
  logic [PtrW-1:0]     r_ptr;
  logic                r_front;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_frame_done;
  logic                r_short_err;
  logic                r_dropped_err;
  logic                w_accept;

  assign w_accept = i_in_valid && (r_state == StWrite);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_ptr         <= '0;
      r_front       <= 1'b0;
      r_wr          <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_frame_done  <= 1'b0;
      r_short_err   <= 1'b0;
      r_dropped_err <= 1'b0;
    end else begin
      r_wr         <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_frame_start) begin
        // Restart always wins; any byte handshaking in the same cycle is dropped.
        r_ptr   <= '0;
        r_state <= StWrite;
        if (r_state == StWrite && r_ptr != '0) r_short_err <= 1'b1;
        if (r_state == StPending) r_dropped_err <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: ;
          StWrite: begin
            if (w_accept) begin
              r_wr   <= 1'b1;
              r_addr <= {~r_front, r_ptr};
              r_data <= i_in_data;
              if (r_ptr == LastPtr) begin
                r_ptr   <= '0;
                r_state <= StPending;
              end else begin
                r_ptr <= r_ptr + 1'b1;
              end
            end
          end
          StPending: begin
            if (i_swap_req) begin
              r_front      <= ~r_front;
              r_frame_done <= 1'b1;
              r_state      <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_in_ready          = (r_state == StWrite);
  assign o_ram_a_address     = r_addr;
  assign o_ram_a_data_in     = r_data;
  assign o_ram_a_clk_enable  = r_wr;
  assign o_ram_a_wr          = r_wr;
  assign o_front_bank        = r_front;
  assign o_frame_done        = r_frame_done;
  assign o_short_frame_err   = r_short_err;
  assign o_dropped_frame_err = r_dropped_err;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer with a 4-byte frame.
module tb_fb_write_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        swap_req = 1'b0;
  logic        in_ready;
  logic [11:0] ram_a_address;
  logic [7:0]  ram_a_data_in;
  logic        ram_a_clk_enable;
  logic        ram_a_wr;
  logic        front_bank;
  logic        frame_done;
  logic        short_frame_err;
  logic        dropped_frame_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fb_write_sequencer #(
    .ADDR_W     (12),
    .DATA_W     (8),
    .FRAME_BYTES(4)
  ) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_frame_start      (frame_start),
    .i_in_valid         (in_valid),
    .i_in_data          (in_data),
    .o_in_ready         (in_ready),
    .i_swap_req         (swap_req),
    .o_ram_a_address    (ram_a_address),
    .o_ram_a_data_in    (ram_a_data_in),
    .o_ram_a_clk_enable (ram_a_clk_enable),
    .o_ram_a_wr         (ram_a_wr),
    .o_front_bank       (front_bank),
    .o_frame_done       (frame_done),
    .o_short_frame_err  (short_frame_err),
    .o_dropped_frame_err(dropped_frame_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    cyc(); cyc();
    reset = 1'b0;
    outs = {in_ready, ram_a_address, ram_a_wr, ram_a_clk_enable, front_bank, frame_done,
            short_frame_err, dropped_frame_err};
    total++;
    if (outs !== 18'h0 || ram_a_data_in !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: got %h/%h want 0/0", outs, ram_a_data_in);
    end
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; cyc(); in_valid = 1'b0;
    total++;
    if (ram_a_wr !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL pre_reset_write: got wr=%b rdy=%b want 1/1", ram_a_wr, in_ready);
    end
    reset = 1'b1; #2;
    outs = {in_ready, ram_a_address, ram_a_wr, ram_a_clk_enable, front_bank, frame_done,
            short_frame_err, dropped_frame_err};
    total++;
    if (outs !== 18'h0) begin
      bad++; $display("FAIL async_reset: got %h want 0", outs);
    end
    cyc(); reset = 1'b0; cyc();
    total++;
    if (in_ready !== 1'b0 || front_bank !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got rdy=%b fb=%b want 0/0", in_ready, front_bank);
    end
  endtask

  // Fills a whole frame and checks each write against the given bank base.
  task automatic test_fill(input logic [11:0] base, input logic [7:0] first);
    logic [11:0] exp_a;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = first + 8'(i); cyc();
      exp_a = base + 12'(i);
      total++;
      if (ram_a_wr !== 1'b1 || ram_a_clk_enable !== 1'b1 || ram_a_address !== exp_a ||
          ram_a_data_in !== first + 8'(i)) begin
        bad++;
        $display("FAIL fill_write%0d: got wr=%b ce=%b a=%h d=%h want 1/1/%h/%h", i, ram_a_wr,
                 ram_a_clk_enable, ram_a_address, ram_a_data_in, exp_a, first + 8'(i));
      end
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_pending_ready: got %b want 0", in_ready);
    end
    cyc();
    total++;
    if (ram_a_wr !== 1'b0) begin
      bad++; $display("FAIL fill_no_extra_write: got %b want 0", ram_a_wr);
    end
  endtask

  task automatic test_swap(input logic exp_fb);
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    total++;
    if (front_bank !== exp_fb || frame_done !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL swap: got fb=%b done=%b rdy=%b want %b/1/0", front_bank, frame_done,
               in_ready, exp_fb);
    end
    cyc();
    total++;
    if (frame_done !== 1'b0 || front_bank !== exp_fb) begin
      bad++; $display("FAIL swap_pulse: got done=%b fb=%b want 0/%b", frame_done, front_bank, exp_fb);
    end
  endtask

  // Front=0 on entry: swap on the final accept is missed, the next one lands.
  task automatic test_swap_miss();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h30 + 8'(i); cyc();
    end
    in_data = 8'h33; swap_req = 1'b1; cyc();
    in_valid = 1'b0; swap_req = 1'b0;
    total++;
    if (ram_a_wr !== 1'b1 || ram_a_address !== 12'h803 || front_bank !== 1'b0 ||
        frame_done !== 1'b0) begin
      bad++;
      $display("FAIL swap_miss_last: got wr=%b a=%h fb=%b done=%b want 1/803/0/0", ram_a_wr,
               ram_a_address, front_bank, frame_done);
    end
    cyc(); cyc();
    total++;
    if (front_bank !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL swap_miss_hold: got fb=%b done=%b want 0/0", front_bank, frame_done);
    end
    test_swap(1'b1);
  endtask

  // Front=1 on entry, back bank base 12'h000.
  task automatic test_short_frame();
    logic [11:0] exp_a;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h41; cyc(); in_data = 8'h42; cyc();
    frame_start = 1'b1; in_data = 8'h55; cyc(); frame_start = 1'b0;
    total++;
    if (short_frame_err !== 1'b1 || ram_a_wr !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL short_err: got err=%b wr=%b rdy=%b want 1/0/1", short_frame_err, ram_a_wr,
               in_ready);
    end
    in_data = "Z"; cyc();
    total++;
    if (ram_a_wr !== 1'b1 || ram_a_address !== 12'h000 || ram_a_data_in !== "Z") begin
      bad++;
      $display("FAIL short_restart: got wr=%b a=%h d=%h want 1/000/5a", ram_a_wr, ram_a_address,
               ram_a_data_in);
    end
    for (int i = 1; i < 4; i++) begin
      in_data = 8'h60 + 8'(i); cyc();
      exp_a = 12'(i);
      total++;
      if (ram_a_address !== exp_a || ram_a_wr !== 1'b1) begin
        bad++; $display("FAIL short_refill%0d: got a=%h wr=%b want %h/1", i, ram_a_address,
                        ram_a_wr, exp_a);
      end
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || dropped_frame_err !== 1'b0) begin
      bad++; $display("FAIL short_pending: got rdy=%b drop=%b want 0/0", in_ready, dropped_frame_err);
    end
  endtask

  // Entered PENDING with front=1: restart plus swap must not swap.
  task automatic test_drop_frame();
    frame_start = 1'b1; swap_req = 1'b1; cyc(); frame_start = 1'b0; swap_req = 1'b0;
    total++;
    if (dropped_frame_err !== 1'b1 || front_bank !== 1'b1 || frame_done !== 1'b0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL drop_err: got drop=%b fb=%b done=%b rdy=%b want 1/1/0/1", dropped_frame_err,
               front_bank, frame_done, in_ready);
    end
    in_valid = 1'b1; in_data = 8'h77; cyc(); in_valid = 1'b0;
    total++;
    if (ram_a_wr !== 1'b1 || ram_a_address !== 12'h000 || ram_a_data_in !== 8'h77) begin
      bad++;
      $display("FAIL drop_refill: got wr=%b a=%h d=%h want 1/000/77", ram_a_wr, ram_a_address,
               ram_a_data_in);
    end
    total++;
    if (short_frame_err !== 1'b1) begin
      bad++; $display("FAIL sticky_short: got %b want 1", short_frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_fill(12'h800, "A");
    test_swap(1'b1);
    test_fill(12'h000, 8'h50);
    test_swap(1'b0);
    test_swap_miss();
    test_short_frame();
    test_drop_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
